// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative multiply
// and unsigned divide/remainder on one shared shift/add-subtract datapath.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               request, accepted when busy=0
//   SrcA, SrcB          operands, sampled at accept
//   ALUControl          op select, sampled at accept
//   busy                high while an iterative op is running
//   done                one-cycle pulse, ALUResult valid
//   ALUResult, Zero     registered result and zero flag, held until next done
module alu_mc #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] SrcA,
  input  logic [N-1:0] SrcB,
  input  logic [3:0]   ALUControl,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] ALUResult,
  output logic         Zero
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [3:0]     op_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   hi_q, hi_d;   // product high half / partial remainder
  logic [N-1:0]   lo_q, lo_d;   // multiplier->product low half / dividend->quotient
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   result_q, result_d;
  logic           zero_q, zero_d;

  logic           accept, iter_in, is_div;
  logic [N-1:0]   simple_res, step_hi, step_lo;
  logic [N:0]     opnd;
  logic [N+1:0]   addend, sum;

  assign accept  = start && (state_q != StRun);
  assign iter_in = (ALUControl[3:2] == 2'b10);
  assign is_div  = op_q[1];

  always_comb begin
    simple_res = '0;
    case (ALUControl)
      4'b0000: simple_res = SrcA & SrcB;
      4'b0001: simple_res = SrcA | SrcB;
      4'b0010: simple_res = SrcA + SrcB;
      4'b0110: simple_res = SrcA + ~SrcB + N'(1);
      4'b0111: simple_res = N'($signed(SrcA) < $signed(SrcB));
      default: simple_res = '0;
    endcase
  end

  // Shared adder. Multiply adds B gated by the multiplier LSB; divide subtracts
  // B from the left-shifted remainder, and the extra top bit flags a borrow.
  always_comb begin
    opnd    = is_div ? {hi_q, lo_q[N-1]} : {1'b0, hi_q};
    addend  = is_div ? ~{2'b00, b_q} : (lo_q[0] ? {2'b00, b_q} : '0);
    sum     = {1'b0, opnd} + addend + {{(N+1){1'b0}}, is_div};
    step_hi = '0;
    step_lo = '0;
    if (!is_div) begin
      step_hi = sum[N:1];
      step_lo = {sum[0], lo_q[N-1:1]};
    end else if (!sum[N+1]) begin
      step_hi = sum[N-1:0];
      step_lo = {lo_q[N-2:0], 1'b1};
    end else begin
      step_hi = opnd[N-1:0];
      step_lo = {lo_q[N-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (iter_in) begin
            state_d = StRun;
            hi_d    = '0;
            lo_d    = SrcA;
            cnt_d   = CW'(N);
          end else begin
            state_d  = StDone;
            result_d = simple_res;
            zero_d   = (simple_res == '0);
          end
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = StDone;
          // MULHU and REMU take the high register, MUL and DIVU the low one.
          result_d = op_q[0] ? step_hi : step_lo;
          zero_d   = op_q[0] ? (step_hi == '0) : (step_lo == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      if (accept) begin
        op_q <= ALUControl;
        b_q  <= SrcB;
      end
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus randomized ops compared
// against a 64-bit arithmetic reference model.
module tb_alu_mc;

  localparam int unsigned N = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  SrcA, SrcB;
  logic [3:0]    ALUControl;
  logic          busy, done, Zero;
  logic [N-1:0]  ALUResult;

  int checks = 0;
  int failures = 0;

  alu_mc #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ALUControl(ALUControl),
    .busy      (busy),
    .done      (done),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_alu(input logic [3:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return N'(longint'(a) + longint'(b));
      4'b0110: return N'(longint'(a) - longint'(b));
      4'b0111: return ($signed(a) < $signed(b)) ? N'(1) : N'(0);
      4'b1000: return p[N-1:0];
      4'b1001: return p[2*N-1:N];
      4'b1010: return (b == 0) ? '1 : N'(a / b);
      4'b1011: return (b == 0) ? a : N'(a % b);
      default: return '0;
    endcase
  endfunction

  function automatic bit is_iter(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  // Entered and left at a negedge. Checks latency, busy width, result and hold.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input bit meddle);
    logic [N-1:0] exp;
    int cycles, busy_cnt;
    exp = ref_alu(op, a, b);
    SrcA = a; SrcB = b; ALUControl = op; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0; busy_cnt = 0;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (done) break;
      if (busy) busy_cnt++;
      if (meddle) begin
        start = 1'($urandom_range(0, 1));
        SrcA = $urandom; SrcB = $urandom; ALUControl = 4'($urandom);
      end
    end
    start = 1'b0;
    check({tag, ".lat"}, cycles, is_iter(op) ? N + 1 : 1);
    check({tag, ".busy"}, busy_cnt, is_iter(op) ? N : 0);
    check({tag, ".res"}, ALUResult, exp);
    check({tag, ".zero"}, Zero, exp == 0);
    @(negedge clk);
    check({tag, ".pulse"}, done, 1'b0);
    check({tag, ".hold"}, ALUResult, exp);
  endtask

  initial begin
    logic [3:0] ops [11];
    logic [3:0] op;
    logic [N-1:0] a, b;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001,
            4'b1010, 4'b1011, 4'b0011, 4'b1110};
    reset = 1'b1; start = 1'b0; SrcA = '0; SrcB = '0; ALUControl = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.res", ALUResult, 0);
    check("rst.zero", Zero, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    do_op("add", 4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
    do_op("sub", 4'b0110, 32'd5, 32'd5, 0);
    do_op("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
    do_op("or", 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
    do_op("slt1", 4'b0111, 32'hFFFF_FFFF, 32'h1, 0);
    do_op("slt0", 4'b0111, 32'h1, 32'hFFFF_FFFF, 0);
    do_op("mul", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    do_op("mulhu", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    do_op("divu", 4'b1010, 32'd100, 32'd7, 0);
    do_op("remu", 4'b1011, 32'd100, 32'd7, 1);
    do_op("div0", 4'b1010, 32'h1234, 32'h0, 0);
    do_op("rem0", 4'b1011, 32'h1234, 32'h0, 0);

    // Back-to-back: ADD accepted in the MUL's DONE cycle.
    SrcA = 32'd6; SrcB = 32'd7; ALUControl = 4'b1000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    begin
      int cycles = 0;
      while (cycles < 100) begin
        @(negedge clk);
        cycles++;
        if (done) break;
      end
      check("b2b.mul_lat", cycles, N + 1);
    end
    check("b2b.mul_res", ALUResult, 42);
    SrcA = 32'd3; SrcB = 32'd4; ALUControl = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b.done", done, 1'b1);
    check("b2b.busy", busy, 1'b0);
    check("b2b.res", ALUResult, 7);
    @(negedge clk);
    check("b2b.idle", done, 1'b0);

    // Reset in the middle of a DIVU.
    SrcA = 32'd1000; SrcB = 32'd3; ALUControl = 4'b1010; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    begin
      int seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (done) seen++;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mrst.seen", seen, 0);
    end
    check("mrst.done", done, 1'b0);
    check("mrst.busy", busy, 1'b0);
    check("mrst.res", ALUResult, 0);
    check("mrst.zero", Zero, 1'b1);
    do_op("post_rst", 4'b0010, 32'd1, 32'd1, 0);

    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 10)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = N'($urandom_range(1, 15));
        2: a = N'($urandom_range(0, 300));
        default: ;
      endcase
      do_op("rand", op, a, b, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
